yeniden_siralama_tamponu: RTL and testbench

YENIDEN_SIRALAMA_TAMPONU -- requirements
Module: yeniden_siralama_tamponu

---
 rtl/yeniden_siralama_tamponu_pkg.sv | 16 +
 rtl/yeniden_siralama_tamponu.sv | 146 ++++++++++++++
 tb/tb_yeniden_siralama_tamponu.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yeniden_siralama_tamponu_pkg.sv
// Shared sizing for the reorder buffer and the blocks that talk to it.
//   DERINLIK_VARSAYILAN   : default number of entries (power of two, max 16)
//   ETIKET_BIT_VARSAYILAN : default tag width, log2(DERINLIK_VARSAYILAN)
//   ADRES_BIT             : register-address (rd) width
//   VERI_BIT              : result data width
package yeniden_siralama_tamponu_pkg;

    localparam int DERINLIK_VARSAYILAN   = 16;
    localparam int ETIKET_BIT_VARSAYILAN = 4;
    localparam int ADRES_BIT             = 5;
    localparam int VERI_BIT              = 32;

    typedef logic [ADRES_BIT-1:0] adres_t;
    typedef logic [VERI_BIT-1:0]  veri_t;

endpackage

// File: rtl/yeniden_siralama_tamponu.sv
// Reorder buffer: hands out tags at dispatch, collects out-of-order results
// from the execution units and retires them to the register file in order.
//
// Ports
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   temizle_i                 : synchronous flush of every in-flight entry
//   ayir_gecerli_i/adres_i    : dispatch asks for a tag for destination rd
//   ayir_hazir_o/etiket_o     : a tag is available / the tag granted (tail)
//   etiket_o/_adres_o/_gecerli_o : rename update (rd now owned by tag)
//   sonuc_gecerli_i/etiket_i/veri_i : result broadcast
//   yaz_veri_o/adres_o/etiket_o/gecerli_o : in-order commit write port
//   oku_etiket_i, oku_veri_o, oku_hazir_o  : operand lookup by tag
//   bos_o, dolu_o             : empty / full
module yeniden_siralama_tamponu
    import yeniden_siralama_tamponu_pkg::*;
#(
    parameter int DERINLIK   = DERINLIK_VARSAYILAN,
    parameter int ETIKET_BIT = ETIKET_BIT_VARSAYILAN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  ayir_gecerli_i,
    input  logic [ADRES_BIT-1:0]  ayir_adres_i,
    output logic                  ayir_hazir_o,
    output logic [ETIKET_BIT-1:0] ayir_etiket_o,

    output logic [ETIKET_BIT-1:0] etiket_o,
    output logic [ADRES_BIT-1:0]  etiket_adres_o,
    output logic                  etiket_gecerli_o,

    input  logic                  sonuc_gecerli_i,
    input  logic [ETIKET_BIT-1:0] sonuc_etiket_i,
    input  logic [VERI_BIT-1:0]   sonuc_veri_i,

    output logic [VERI_BIT-1:0]   yaz_veri_o,
    output logic [ADRES_BIT-1:0]  yaz_adres_o,
    output logic [ETIKET_BIT-1:0] yaz_etiket_o,
    output logic                  yaz_gecerli_o,

    input  logic [ETIKET_BIT-1:0] oku_etiket_i,
    output logic [VERI_BIT-1:0]   oku_veri_o,
    output logic                  oku_hazir_o,

    input  logic                  temizle_i,

    output logic                  bos_o,
    output logic                  dolu_o
);

    localparam int SAYAC_BIT = ETIKET_BIT + 1;
    localparam logic [SAYAC_BIT-1:0] DERINLIK_S = SAYAC_BIT'(DERINLIK);

    logic [ETIKET_BIT-1:0] bas_q;
    logic [ETIKET_BIT-1:0] kuyruk_q;
    logic [SAYAC_BIT-1:0]  sayac_q;
    logic [DERINLIK-1:0]   dolu_q;
    logic [DERINLIK-1:0]   hazir_q;
    adres_t                adres_q [DERINLIK];
    veri_t                 veri_q  [DERINLIK];

    logic ayir;
    logic yaz;
    logic sonuc_kabul;

    always_comb begin
        // Full is judged on the registered count, so a slot freed by a commit
        // this cycle only becomes allocatable on the next one.
        ayir_hazir_o = (sayac_q < DERINLIK_S) && !temizle_i;
        ayir         = ayir_gecerli_i && ayir_hazir_o;
        yaz          = (sayac_q != '0) && hazir_q[bas_q] && !temizle_i;
        // Stale or duplicate results (entry free, or already holding data)
        // must not corrupt anything.
        sonuc_kabul  = sonuc_gecerli_i && dolu_q[sonuc_etiket_i]
                       && !hazir_q[sonuc_etiket_i];
    end

    always_comb begin
        ayir_etiket_o    = kuyruk_q;
        etiket_o         = kuyruk_q;
        etiket_adres_o   = ayir_adres_i;
        // ayir_hazir_o stays high while in reset, so the rename strobe is
        // gated by reset explicitly to keep the register file untouched.
        etiket_gecerli_o = ayir && (ayir_adres_i != '0) && !rst_i;

        yaz_veri_o       = veri_q[bas_q];
        yaz_adres_o      = adres_q[bas_q];
        yaz_etiket_o     = bas_q;
        yaz_gecerli_o    = yaz && (adres_q[bas_q] != '0);

        oku_veri_o       = veri_q[oku_etiket_i];
        oku_hazir_o      = dolu_q[oku_etiket_i] && hazir_q[oku_etiket_i];

        bos_o            = (sayac_q == '0);
        dolu_o           = (sayac_q == DERINLIK_S);
    end

    // Allocate writes the tail slot and commit clears the head slot; they can
    // only coincide when the buffer is empty or full, where one of them is
    // already blocked. A result can never land on either slot in that cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bas_q    <= '0;
            kuyruk_q <= '0;
            sayac_q  <= '0;
            dolu_q   <= '0;
            hazir_q  <= '0;
        end else if (temizle_i) begin
            bas_q    <= '0;
            kuyruk_q <= '0;
            sayac_q  <= '0;
            dolu_q   <= '0;
            hazir_q  <= '0;
        end else begin
            if (ayir) begin
                kuyruk_q          <= kuyruk_q + 1'b1;
                dolu_q[kuyruk_q]  <= 1'b1;
                hazir_q[kuyruk_q] <= 1'b0;
            end
            if (yaz) begin
                bas_q          <= bas_q + 1'b1;
                dolu_q[bas_q]  <= 1'b0;
                hazir_q[bas_q] <= 1'b0;
            end
            if (sonuc_kabul) begin
                hazir_q[sonuc_etiket_i] <= 1'b1;
            end
            case ({ayir, yaz})
                2'b10:   sayac_q <= sayac_q + 1'b1;
                2'b01:   sayac_q <= sayac_q - 1'b1;
                default: sayac_q <= sayac_q;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives in dolu_q/hazir_q.
    always_ff @(posedge clk_i) begin
        if (ayir) begin
            adres_q[kuyruk_q] <= ayir_adres_i;
        end
        if (sonuc_kabul) begin
            veri_q[sonuc_etiket_i] <= sonuc_veri_i;
        end
    end

endmodule

// File: tb/tb_yeniden_siralama_tamponu.sv
module tb_yeniden_siralama_tamponu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        ayir_gecerli_i = 1'b0;
    logic [4:0]  ayir_adres_i = '0;
    logic        ayir_hazir_o;
    logic [3:0]  ayir_etiket_o;
    logic [3:0]  etiket_o;
    logic [4:0]  etiket_adres_o;
    logic        etiket_gecerli_o;
    logic        sonuc_gecerli_i = 1'b0;
    logic [3:0]  sonuc_etiket_i = '0;
    logic [31:0] sonuc_veri_i = '0;
    logic [31:0] yaz_veri_o;
    logic [4:0]  yaz_adres_o;
    logic [3:0]  yaz_etiket_o;
    logic        yaz_gecerli_o;
    logic [3:0]  oku_etiket_i = '0;
    logic [31:0] oku_veri_o;
    logic        oku_hazir_o;
    logic        temizle_i = 1'b0;
    logic        bos_o;
    logic        dolu_o;

    int checks = 0;
    int errors = 0;

    yeniden_siralama_tamponu #(.DERINLIK(16), .ETIKET_BIT(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ayir_gecerli_i   (ayir_gecerli_i),
        .ayir_adres_i     (ayir_adres_i),
        .ayir_hazir_o     (ayir_hazir_o),
        .ayir_etiket_o    (ayir_etiket_o),
        .etiket_o         (etiket_o),
        .etiket_adres_o   (etiket_adres_o),
        .etiket_gecerli_o (etiket_gecerli_o),
        .sonuc_gecerli_i  (sonuc_gecerli_i),
        .sonuc_etiket_i   (sonuc_etiket_i),
        .sonuc_veri_i     (sonuc_veri_i),
        .yaz_veri_o       (yaz_veri_o),
        .yaz_adres_o      (yaz_adres_o),
        .yaz_etiket_o     (yaz_etiket_o),
        .yaz_gecerli_o    (yaz_gecerli_o),
        .oku_etiket_i     (oku_etiket_i),
        .oku_veri_o       (oku_veri_o),
        .oku_hazir_o      (oku_hazir_o),
        .temizle_i        (temizle_i),
        .bos_o            (bos_o),
        .dolu_o           (dolu_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after a rising edge; checks run 2 units later.
    task automatic adim();
        @(posedge clk_i);
        #1;
    endtask

    task automatic girisleri_sifirla();
        ayir_gecerli_i  = 1'b0;
        ayir_adres_i    = '0;
        sonuc_gecerli_i = 1'b0;
        sonuc_etiket_i  = '0;
        sonuc_veri_i    = '0;
        oku_etiket_i    = '0;
        temizle_i       = 1'b0;
    endtask

    task automatic sifirla();
        girisleri_sifirla();
        #2 rst_i = 1'b1;
        #2 rst_i = 1'b0;
        adim();
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        #1;
        checks++; if (ayir_hazir_o !== 1'b1) begin errors++; $display("FAIL reset_ayir_hazir: got %b expected 1", ayir_hazir_o); end
        checks++; if (ayir_etiket_o !== 4'd0) begin errors++; $display("FAIL reset_ayir_etiket: got %0d expected 0", ayir_etiket_o); end
        checks++; if (etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_etiket_gecerli: got %b expected 0", etiket_gecerli_o); end
        checks++; if (yaz_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_yaz_gecerli: got %b expected 0", yaz_gecerli_o); end
        checks++; if (oku_hazir_o !== 1'b0) begin errors++; $display("FAIL reset_oku_hazir: got %b expected 0", oku_hazir_o); end
        checks++; if (bos_o !== 1'b1) begin errors++; $display("FAIL reset_bos: got %b expected 1", bos_o); end
        checks++; if (dolu_o !== 1'b0) begin errors++; $display("FAIL reset_dolu: got %b expected 0", dolu_o); end
        #5 rst_i = 1'b0;
        adim();
    endtask

    task automatic test_temel();
        sifirla();
        ayir_gecerli_i = 1'b1; ayir_adres_i = 5'd5;
        #2;
        checks++; if (etiket_gecerli_o !== 1'b1) begin errors++; $display("FAIL temel_etiket_gecerli: got %b expected 1", etiket_gecerli_o); end
        checks++; if (etiket_o !== 4'd0) begin errors++; $display("FAIL temel_etiket: got %0d expected 0", etiket_o); end
        checks++; if (etiket_adres_o !== 5'd5) begin errors++; $display("FAIL temel_etiket_adres: got %0d expected 5", etiket_adres_o); end
        adim();
        ayir_gecerli_i = 1'b0;
        sonuc_gecerli_i = 1'b1; sonuc_etiket_i = 4'd0; sonuc_veri_i = 32'hDEADBEEF;
        oku_etiket_i = 4'd0;
        #2;
        checks++; if (yaz_gecerli_o !== 1'b0) begin errors++; $display("FAIL temel_no_bypass: got %b expected 0", yaz_gecerli_o); end
        checks++; if (oku_hazir_o !== 1'b0) begin errors++; $display("FAIL temel_no_forward: got %b expected 0", oku_hazir_o); end
        adim();
        sonuc_gecerli_i = 1'b0;
        #2;
        checks++; if (yaz_gecerli_o !== 1'b1) begin errors++; $display("FAIL temel_yaz_gecerli: got %b expected 1", yaz_gecerli_o); end
        checks++; if (yaz_adres_o !== 5'd5) begin errors++; $display("FAIL temel_yaz_adres: got %0d expected 5", yaz_adres_o); end
        checks++; if (yaz_veri_o !== 32'hDEADBEEF) begin errors++; $display("FAIL temel_yaz_veri: got %h expected deadbeef", yaz_veri_o); end
        checks++; if (yaz_etiket_o !== 4'd0) begin errors++; $display("FAIL temel_yaz_etiket: got %0d expected 0", yaz_etiket_o); end
        checks++; if (oku_hazir_o !== 1'b1) begin errors++; $display("FAIL temel_oku_hazir: got %b expected 1", oku_hazir_o); end
        checks++; if (oku_veri_o !== 32'hDEADBEEF) begin errors++; $display("FAIL temel_oku_veri: got %h expected deadbeef", oku_veri_o); end
        adim();
        #2;
        checks++; if (bos_o !== 1'b1) begin errors++; $display("FAIL temel_bos: got %b expected 1", bos_o); end
        checks++; if (yaz_gecerli_o !== 1'b0) begin errors++; $display("FAIL temel_yaz_bitti: got %b expected 0", yaz_gecerli_o); end
    endtask

    task automatic test_sirasiz();
        logic [3:0] sira [3];
        logic [3:0] etk;
        sira[0] = 4'd2; sira[1] = 4'd0; sira[2] = 4'd1;
        sifirla();
        for (int i = 0; i < 3; i++) begin
            ayir_gecerli_i = 1'b1; ayir_adres_i = 5'(i + 1);
            #2;
            checks++; if (ayir_etiket_o !== 4'(i)) begin errors++; $display("FAIL sirasiz_etiket%0d: got %0d expected %0d", i, ayir_etiket_o, i); end
            adim();
        end
        ayir_gecerli_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            etk = sira[i];
            sonuc_gecerli_i = 1'b1; sonuc_etiket_i = etk; sonuc_veri_i = 32'h1000 + 32'(etk);
            #2;
            if (i == 0) begin
                checks++; if (yaz_gecerli_o !== 1'b0) begin errors++; $display("FAIL sirasiz_erken: got %b expected 0", yaz_gecerli_o); end
            end
            if (i == 2) begin
                checks++; if (yaz_gecerli_o !== 1'b1 || yaz_etiket_o !== 4'd0) begin errors++; $display("FAIL sirasiz_commit0: got v=%b t=%0d expected v=1 t=0", yaz_gecerli_o, yaz_etiket_o); end
                checks++; if (yaz_veri_o !== 32'h1000) begin errors++; $display("FAIL sirasiz_veri0: got %h expected 00001000", yaz_veri_o); end
            end
            adim();
        end
        sonuc_gecerli_i = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #2;
            checks++; if (yaz_gecerli_o !== 1'b1 || yaz_etiket_o !== 4'(i)) begin errors++; $display("FAIL sirasiz_commit%0d: got v=%b t=%0d expected v=1 t=%0d", i, yaz_gecerli_o, yaz_etiket_o, i); end
            checks++; if (yaz_adres_o !== 5'(i + 1) || yaz_veri_o !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL sirasiz_yaz%0d: got a=%0d d=%h expected a=%0d d=%h", i, yaz_adres_o, yaz_veri_o, i + 1, 32'h1000 + 32'(i)); end
            adim();
        end
        #2;
        checks++; if (bos_o !== 1'b1) begin errors++; $display("FAIL sirasiz_bos: got %b expected 1", bos_o); end
    endtask

    task automatic test_dolu_sarma();
        sifirla();
        for (int i = 0; i < 16; i++) begin
            ayir_gecerli_i = 1'b1; ayir_adres_i = 5'(i + 1);
            #2;
            checks++; if (ayir_etiket_o !== 4'(i) || ayir_hazir_o !== 1'b1) begin errors++; $display("FAIL dolu_ayir%0d: got t=%0d h=%b expected t=%0d h=1", i, ayir_etiket_o, ayir_hazir_o, i); end
            adim();
        end
        ayir_adres_i = 5'd9;
        #2;
        checks++; if (dolu_o !== 1'b1) begin errors++; $display("FAIL dolu_flag: got %b expected 1", dolu_o); end
        checks++; if (ayir_hazir_o !== 1'b0) begin errors++; $display("FAIL dolu_ayir_hazir: got %b expected 0", ayir_hazir_o); end
        checks++; if (etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL dolu_etiket_gecerli: got %b expected 0", etiket_gecerli_o); end
        sonuc_gecerli_i = 1'b1; sonuc_etiket_i = 4'd0; sonuc_veri_i = 32'hA0;
        adim();
        sonuc_gecerli_i = 1'b0;
        #2;
        checks++; if (yaz_gecerli_o !== 1'b1 || yaz_adres_o !== 5'd1 || yaz_veri_o !== 32'hA0) begin errors++; $display("FAIL dolu_commit: got v=%b a=%0d d=%h expected v=1 a=1 d=000000a0", yaz_gecerli_o, yaz_adres_o, yaz_veri_o); end
        checks++; if (ayir_hazir_o !== 1'b0 || etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL dolu_ayni_cevrim: got h=%b g=%b expected h=0 g=0", ayir_hazir_o, etiket_gecerli_o); end
        adim();
        #2;
        checks++; if (ayir_hazir_o !== 1'b1 || dolu_o !== 1'b0) begin errors++; $display("FAIL sarma_hazir: got h=%b d=%b expected h=1 d=0", ayir_hazir_o, dolu_o); end
        checks++; if (etiket_gecerli_o !== 1'b1 || etiket_o !== 4'd0 || ayir_etiket_o !== 4'd0) begin errors++; $display("FAIL sarma_etiket: got g=%b t=%0d expected g=1 t=0", etiket_gecerli_o, etiket_o); end
        adim();
        ayir_gecerli_i = 1'b0;
        #2;
        checks++; if (dolu_o !== 1'b1 || ayir_etiket_o !== 4'd1) begin errors++; $display("FAIL sarma_sonra: got d=%b t=%0d expected d=1 t=1", dolu_o, ayir_etiket_o); end
    endtask

    task automatic test_rd_sifir();
        sifirla();
        ayir_gecerli_i = 1'b1; ayir_adres_i = 5'd0;
        #2;
        checks++; if (etiket_gecerli_o !== 1'b0 || ayir_hazir_o !== 1'b1) begin errors++; $display("FAIL rd0_etiket: got g=%b h=%b expected g=0 h=1", etiket_gecerli_o, ayir_hazir_o); end
        adim();
        ayir_gecerli_i = 1'b0;
        sonuc_gecerli_i = 1'b1; sonuc_etiket_i = 4'd0; sonuc_veri_i = 32'h1234;
        #2;
        checks++; if (bos_o !== 1'b0) begin errors++; $display("FAIL rd0_dolu_kayit: got %b expected 0", bos_o); end
        adim();
        sonuc_gecerli_i = 1'b0;
        #2;
        checks++; if (yaz_gecerli_o !== 1'b0) begin errors++; $display("FAIL rd0_yaz: got %b expected 0", yaz_gecerli_o); end
        adim();
        #2;
        checks++; if (bos_o !== 1'b1 || ayir_etiket_o !== 4'd1) begin errors++; $display("FAIL rd0_emekli: got b=%b t=%0d expected b=1 t=1", bos_o, ayir_etiket_o); end
    endtask

    task automatic test_bos_etiket();
        sifirla();
        ayir_gecerli_i = 1'b1; ayir_adres_i = 5'd9;
        adim();
        ayir_gecerli_i = 1'b0;
        sonuc_gecerli_i = 1'b1; sonuc_etiket_i = 4'd7; sonuc_veri_i = 32'h77;
        adim();
        sonuc_gecerli_i = 1'b0;
        oku_etiket_i = 4'd7;
        #2;
        checks++; if (oku_hazir_o !== 1'b0) begin errors++; $display("FAIL bos7_oku_hazir: got %b expected 0", oku_hazir_o); end
        checks++; if (bos_o !== 1'b0 || ayir_etiket_o !== 4'd1 || yaz_gecerli_o !== 1'b0) begin errors++; $display("FAIL bos7_durum: got b=%b t=%0d y=%b expected b=0 t=1 y=0", bos_o, ayir_etiket_o, yaz_gecerli_o); end
        oku_etiket_i = 4'd0;
        #1;
        checks++; if (oku_hazir_o !== 1'b0) begin errors++; $display("FAIL bos7_etiket0: got %b expected 0", oku_hazir_o); end
    endtask

    task automatic test_temizle();
        sifirla();
        for (int i = 0; i < 3; i++) begin
            ayir_gecerli_i = 1'b1; ayir_adres_i = 5'(i + 4);
            adim();
        end
        ayir_gecerli_i = 1'b0;
        sonuc_gecerli_i = 1'b1; sonuc_etiket_i = 4'd0; sonuc_veri_i = 32'h55;
        adim();
        sonuc_gecerli_i = 1'b0;
        temizle_i = 1'b1; ayir_gecerli_i = 1'b1; ayir_adres_i = 5'd3;
        #2;
        checks++; if (yaz_gecerli_o !== 1'b0) begin errors++; $display("FAIL temizle_yaz: got %b expected 0", yaz_gecerli_o); end
        checks++; if (ayir_hazir_o !== 1'b0 || etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL temizle_ayir: got h=%b g=%b expected h=0 g=0", ayir_hazir_o, etiket_gecerli_o); end
        adim();
        temizle_i = 1'b0; ayir_gecerli_i = 1'b0;
        #2;
        checks++; if (bos_o !== 1'b1 || ayir_etiket_o !== 4'd0) begin errors++; $display("FAIL temizle_sonra: got b=%b t=%0d expected b=1 t=0", bos_o, ayir_etiket_o); end
        checks++; if (oku_hazir_o !== 1'b0 || yaz_gecerli_o !== 1'b0) begin errors++; $display("FAIL temizle_kayit: got o=%b y=%b expected o=0 y=0", oku_hazir_o, yaz_gecerli_o); end
    endtask

    task automatic test_async_reset();
        sifirla();
        for (int i = 0; i < 2; i++) begin
            ayir_gecerli_i = 1'b1; ayir_adres_i = 5'(i + 3);
            adim();
        end
        ayir_gecerli_i = 1'b0;
        sonuc_gecerli_i = 1'b1; sonuc_etiket_i = 4'd0; sonuc_veri_i = 32'h99;
        adim();
        sonuc_gecerli_i = 1'b0;
        oku_etiket_i = 4'd0;
        ayir_gecerli_i = 1'b1; ayir_adres_i = 5'd7;
        #1;
        checks++; if (yaz_gecerli_o !== 1'b1 || oku_hazir_o !== 1'b1) begin errors++; $display("FAIL areset_once: got y=%b o=%b expected y=1 o=1", yaz_gecerli_o, oku_hazir_o); end
        #1 rst_i = 1'b1;
        #1;
        checks++; if (yaz_gecerli_o !== 1'b0 || oku_hazir_o !== 1'b0 || etiket_gecerli_o !== 1'b0) begin errors++; $display("FAIL areset_gecerli: got y=%b o=%b g=%b expected 0 0 0", yaz_gecerli_o, oku_hazir_o, etiket_gecerli_o); end
        checks++; if (ayir_hazir_o !== 1'b1 || ayir_etiket_o !== 4'd0 || bos_o !== 1'b1 || dolu_o !== 1'b0) begin errors++; $display("FAIL areset_durum: got h=%b t=%0d b=%b d=%b expected 1 0 1 0", ayir_hazir_o, ayir_etiket_o, bos_o, dolu_o); end
        ayir_gecerli_i = 1'b0;
        adim();
        #2 rst_i = 1'b0;
        adim();
        sonuc_gecerli_i = 1'b1; sonuc_etiket_i = 4'd1; sonuc_veri_i = 32'hAA;
        adim();
        sonuc_gecerli_i = 1'b0;
        oku_etiket_i = 4'd1;
        #2;
        checks++; if (yaz_gecerli_o !== 1'b0 || oku_hazir_o !== 1'b0 || bos_o !== 1'b1) begin errors++; $display("FAIL areset_kayip: got y=%b o=%b b=%b expected 0 0 1", yaz_gecerli_o, oku_hazir_o, bos_o); end
    endtask

    initial begin
        test_reset();
        test_temel();
        test_sirasiz();
        test_dolu_sarma();
        test_rd_sifir();
        test_bos_etiket();
        test_temizle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
